// File: rtl/cnf_pkg.sv
// ---------------------------------------------------------------------------
// cnf_pkg : shared state encoding, saturating increment and slice macro
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef CNF_CH_SLICE
`define CNF_CH_SLICE(c, w) [(c)*(w) +: (w)]
`endif

package cnf_pkg;

  typedef enum logic [0:0] {
    ST_EVAL = 1'b0,
    ST_DONE = 1'b1
  } cnf_state_e;

  // Increment that sticks at the all-ones value of a WIDTH-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : val + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnf_clause_lane.sv
// ---------------------------------------------------------------------------
// cnf_clause_lane : per-channel clause OR, formula AND and unsat-clause count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cnf_clause_lane
  import cnf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic             accept_i,
  input  logic             close_i,
  input  logic             clear_i,
  output logic             sat_o,
  output logic [CNT_W-1:0] unsat_o
);

  logic             clause_q, clause_d;
  logic             cnf_q, cnf_d;
  logic [CNT_W-1:0] unsat_q, unsat_d;
  logic             clause_val;

  always_comb begin
    clause_val = clause_q | v_i;
    clause_d   = clause_q;
    cnf_d      = cnf_q;
    unsat_d    = unsat_q;
    if (clear_i) begin
      clause_d = 1'b0;
      cnf_d    = 1'b1;
      unsat_d  = '0;
    end else if (accept_i) begin
      if (close_i) begin
        clause_d = 1'b0;
        cnf_d    = cnf_q & clause_val;
        if (!clause_val) begin
          unsat_d = CNT_W'(sat_inc(32'(unsat_q), CNT_W));
        end
      end else begin
        clause_d = clause_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clause_q <= 1'b0;
      cnf_q    <= 1'b1;
      unsat_q  <= '0;
    end else begin
      clause_q <= clause_d;
      cnf_q    <= cnf_d;
      unsat_q  <= unsat_d;
    end
  end

  assign sat_o   = cnf_q;
  assign unsat_o = unsat_q;

endmodule

`default_nettype wire

// File: rtl/cnf_eval_engine.sv
// ---------------------------------------------------------------------------
// cnf_eval_engine : streams CNF literals and evaluates NUM_CH assignments in parallel
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cnf_eval_engine
  import cnf_pkg::*;
#(
  parameter int NUM_VARS = 32,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter logic [NUM_CH*NUM_VARS-1:0] INIT_ASSIGN = '0,
  localparam int VAR_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       loadAssign,
  input  logic [NUM_CH*NUM_VARS-1:0] assignIn,
  input  logic                       litValid,
  output logic                       litReady,
  input  logic [VAR_W-1:0]           litVar,
  input  logic                       litNeg,
  input  logic                       litLastClause,
  input  logic                       litLastFormula,
  output logic                       resValid,
  input  logic                       resReady,
  output logic [NUM_CH-1:0]          resSat,
  output logic [NUM_CH*CNT_W-1:0]    resUnsatCnt,
  output logic [CNT_W-1:0]           resClauseCnt,
  output logic                       errFlag
);

  cnf_state_e                 state_q, state_d;
  logic [NUM_CH*NUM_VARS-1:0] assign_q, assign_d;
  logic                       in_formula_q, in_formula_d;
  logic                       err_q, err_d;
  logic [CNT_W-1:0]           clause_cnt_q, clause_cnt_d;

  logic                       accept;
  logic                       close_clause;
  logic                       clear_result;
  logic                       var_bad;
  logic [NUM_CH-1:0]          lit_val;

  // Load has priority over literals in the same cycle
  assign litReady     = (state_q == ST_EVAL) && !loadAssign;
  assign accept       = litValid && litReady;
  assign close_clause = litLastClause | litLastFormula;
  assign clear_result = (state_q == ST_DONE) && resReady;

  // Out-of-range indices only exist when NUM_VARS is not a power of two
  if (NUM_VARS < (1 << VAR_W)) begin : g_var_range_chk
    assign var_bad = (litVar >= VAR_W'(NUM_VARS));
  end else begin : g_var_range_full
    assign var_bad = 1'b0;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic [NUM_VARS-1:0] ch_assign;
    logic [CNT_W-1:0]    ch_unsat;

    assign ch_assign  = assign_q `CNF_CH_SLICE(c, NUM_VARS);
    assign lit_val[c] = !var_bad && (ch_assign[litVar] ^ litNeg);

    cnf_clause_lane #(
      .CNT_W (CNT_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .v_i      (lit_val[c]),
      .accept_i (accept),
      .close_i  (close_clause),
      .clear_i  (clear_result),
      .sat_o    (resSat[c]),
      .unsat_o  (ch_unsat)
    );

    assign resUnsatCnt `CNF_CH_SLICE(c, CNT_W) = ch_unsat;
  end

  always_comb begin
    state_d  = state_q;
    resValid = 1'b0;
    case (state_q)
      ST_EVAL: begin
        if (accept && litLastFormula) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        resValid = 1'b1;
        if (resReady) begin
          state_d = ST_EVAL;
        end
      end
      default: state_d = ST_EVAL;
    endcase
  end

  always_comb begin
    assign_d     = assign_q;
    in_formula_d = in_formula_q;
    err_d        = err_q;
    clause_cnt_d = clause_cnt_q;
    if (loadAssign) begin
      if ((state_q == ST_EVAL) && !in_formula_q) begin
        assign_d = assignIn;
      end else begin
        err_d = 1'b1;
      end
    end
    if (accept) begin
      in_formula_d = !litLastFormula;
      if (var_bad) begin
        err_d = 1'b1;
      end
      if (close_clause) begin
        clause_cnt_d = CNT_W'(sat_inc(32'(clause_cnt_q), CNT_W));
      end
    end
    if (clear_result) begin
      clause_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EVAL;
      assign_q     <= INIT_ASSIGN;
      in_formula_q <= 1'b0;
      err_q        <= 1'b0;
      clause_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      assign_q     <= assign_d;
      in_formula_q <= in_formula_d;
      err_q        <= err_d;
      clause_cnt_q <= clause_cnt_d;
    end
  end

  assign resClauseCnt = clause_cnt_q;
  assign errFlag      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cnf_eval_engine.sv
// ---------------------------------------------------------------------------
// tb_cnf_eval_engine : directed bench with a formula-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cnf_eval_engine;

  localparam int NV = 24;
  localparam int NC = 2;
  localparam int CW = 4;
  localparam int VW = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [NC*NV-1:0] INIT = {24'h000000, 24'h000001};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             loadAssign = 1'b0;
  logic [NC*NV-1:0] assignIn = '0;
  logic             litValid = 1'b0;
  logic             litReady;
  logic [VW-1:0]    litVar = '0;
  logic             litNeg = 1'b0;
  logic             litLastClause = 1'b0;
  logic             litLastFormula = 1'b0;
  logic             resValid;
  logic             resReady = 1'b0;
  logic [NC-1:0]    resSat;
  logic [NC*CW-1:0] resUnsatCnt;
  logic [CW-1:0]    resClauseCnt;
  logic             errFlag;

  cnf_eval_engine #(
    .NUM_VARS    (NV),
    .NUM_CH      (NC),
    .CNT_W       (CW),
    .INIT_ASSIGN (INIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .loadAssign     (loadAssign),
    .assignIn       (assignIn),
    .litValid       (litValid),
    .litReady       (litReady),
    .litVar         (litVar),
    .litNeg         (litNeg),
    .litLastClause  (litLastClause),
    .litLastFormula (litLastFormula),
    .resValid       (resValid),
    .resReady       (resReady),
    .resSat         (resSat),
    .resUnsatCnt    (resUnsatCnt),
    .resClauseCnt   (resClauseCnt),
    .errFlag        (errFlag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collects a formula's literals, evaluates it as a whole at the end
  typedef struct {
    int v;
    bit n;
    bit lc;
    bit lf;
  } lit_t;

  bit            m_rv;
  bit            m_err;
  bit            m_inform;
  logic [NV-1:0] m_a [NC];
  lit_t          cur[$];
  logic [NC-1:0] m_sat;
  int            m_unsat [NC];
  int            m_cc;

  always @(posedge clk) begin : model
    bit   rdy;
    int   raw [NC];
    bit   t [NC];
    int   cc;
    lit_t l;
    if (reset) begin
      m_rv = 0; m_err = 0; m_inform = 0;
      for (int c = 0; c < NC; c++) m_a[c] = INIT[c*NV +: NV];
      cur.delete();
    end else begin
      rdy = !m_rv && !loadAssign;
      if (loadAssign) begin
        if (!m_rv && !m_inform) for (int c = 0; c < NC; c++) m_a[c] = assignIn[c*NV +: NV];
        else m_err = 1;
      end
      if (m_rv) begin
        if (resReady) m_rv = 0;
      end else if (litValid && rdy) begin
        l.v = int'(litVar); l.n = litNeg; l.lc = litLastClause; l.lf = litLastFormula;
        if (l.v >= NV) m_err = 1;
        cur.push_back(l);
        m_inform = !litLastFormula;
        if (litLastFormula) begin
          cc = 0;
          for (int c = 0; c < NC; c++) begin raw[c] = 0; t[c] = 0; end
          foreach (cur[i]) begin
            for (int c = 0; c < NC; c++)
              if (cur[i].v < NV) t[c] = t[c] | (m_a[c][cur[i].v] ^ cur[i].n);
            if (cur[i].lc || cur[i].lf) begin
              cc++;
              for (int c = 0; c < NC; c++) begin
                if (!t[c]) raw[c]++;
                t[c] = 0;
              end
            end
          end
          for (int c = 0; c < NC; c++) begin
            m_sat[c]   = (raw[c] == 0);
            m_unsat[c] = (raw[c] > CMAX) ? CMAX : raw[c];
          end
          m_cc = (cc > CMAX) ? CMAX : cc;
          m_rv = 1;
          cur.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("litReady", litReady, !m_rv && !loadAssign);
      chk("resValid", resValid, m_rv);
      chk("errFlag", errFlag, m_err);
      if (m_rv) begin
        chk("resSat", resSat, m_sat);
        for (int c = 0; c < NC; c++) chk("resUnsatCnt", resUnsatCnt[c*CW +: CW], m_unsat[c]);
        chk("resClauseCnt", resClauseCnt, m_cc);
      end
    end
  end

  task automatic send_lit(input int v, input bit n, input bit lc, input bit lf);
    bit rdy;
    int k;
    litValid = 1'b1; litVar = VW'(v); litNeg = n; litLastClause = lc; litLastFormula = lf;
    rdy = 0; k = 0;
    while (!rdy && k < 40) begin
      @(negedge clk);
      rdy = litReady;
      @(posedge clk);
      k++;
    end
    #1;
    litValid = 1'b0; litLastClause = 1'b0; litLastFormula = 1'b0;
    total++;
    if (!rdy) begin
      bad++;
      $display("FAIL lit_accept: got no accept expected accept within 40 cycles");
    end
  endtask

  task automatic take();
    bit got;
    int k;
    resReady = 1'b1;
    got = 0; k = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      got = resValid;
      @(posedge clk);
      k++;
    end
    #1;
    resReady = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL res_handshake: got no resValid expected resValid within 40 cycles");
    end
  endtask

  task automatic load(input logic [NV-1:0] a0, input logic [NV-1:0] a1);
    loadAssign = 1'b1;
    assignIn   = {a1, a0};
    @(posedge clk);
    #1;
    loadAssign = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cycles(3);
    reset = 1'b0;
    #1;
    chk("rst_resSat", resSat, 2'b11);
    chk("rst_unsat", resUnsatCnt, 0);
    chk("rst_clauseCnt", resClauseCnt, 0);
    chk("rst_litReady", litReady, 1);
    chk("rst_resValid", resValid, 0);
    chk("rst_errFlag", errFlag, 0);

    // reset assignment: ch0 x0=1, ch1 x0=0; formula x0
    send_lit(0, 0, 1, 1);
    chk("init_resSat", resSat, 2'b01);
    chk("init_unsat1", resUnsatCnt[CW +: CW], 1);
    take();

    // (x0|~x1)&(x1|x2) with ch0=0x5, ch1=0x2
    load(24'h5, 24'h2);
    send_lit(0, 0, 0, 0);
    send_lit(1, 1, 1, 0);
    send_lit(1, 0, 0, 0);
    send_lit(2, 0, 1, 1);
    chk("f1_resValid", resValid, 1);
    chk("f1_resSat", resSat, 2'b01);
    chk("f1_unsat", resUnsatCnt, {4'd1, 4'd0});
    chk("f1_clauseCnt", resClauseCnt, 2);
    cycles(4);
    load(24'hFF, 24'hFF);
    cycles(5);
    chk("done_litReady", litReady, 0);
    chk("done_errFlag", errFlag, 1);
    chk("done_resSat_hold", resSat, 2'b01);
    chk("done_clauseCnt_hold", resClauseCnt, 2);
    take();

    // single literal ~x3, ch0 x3=1
    load(24'h8, 24'h0);
    send_lit(3, 1, 1, 1);
    chk("neg_resSat", resSat, 2'b10);
    chk("neg_unsat0", resUnsatCnt[0 +: CW], 1);
    take();

    // load and literal in the same cycle: load wins, literal next cycle
    loadAssign = 1'b1; assignIn = {24'h0, 24'h1};
    litValid = 1'b1; litVar = 0; litNeg = 0; litLastClause = 1; litLastFormula = 1;
    #1;
    chk("load_litReady", litReady, 0);
    @(posedge clk);
    #1;
    loadAssign = 1'b0;
    send_lit(0, 0, 1, 1);
    chk("load_resSat", resSat, 2'b01);
    take();

    // reset mid-formula
    send_lit(1, 0, 0, 0);
    send_lit(2, 0, 1, 0);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    #1;
    chk("mid_rst_resSat", resSat, 2'b11);
    chk("mid_rst_clauseCnt", resClauseCnt, 0);
    chk("mid_rst_errFlag", errFlag, 0);
    chk("mid_rst_resValid", resValid, 0);
    send_lit(0, 0, 1, 1);
    chk("mid_rst_f_clauseCnt", resClauseCnt, 1);
    take();

    // out-of-range variable reads as false even when negated
    send_lit(30, 1, 1, 1);
    chk("badvar_resSat", resSat, 2'b00);
    chk("badvar_errFlag", errFlag, 1);
    chk("badvar_unsat", resUnsatCnt, {4'd1, 4'd1});
    take();

    // 20 false clauses saturate 4-bit counters
    for (int i = 0; i < 20; i++) send_lit(5, 0, 1, i == 19);
    chk("sat_unsat", resUnsatCnt, {4'd15, 4'd15});
    chk("sat_clauseCnt", resClauseCnt, 15);
    take();

    // back-to-back with resReady tied high
    resReady = 1'b1;
    send_lit(0, 0, 1, 1);
    send_lit(0, 1, 0, 0);
    send_lit(5, 0, 1, 1);
    chk("b2b_resValid", resValid, 1);
    chk("b2b_resSat", resSat, 2'b10);
    chk("b2b_clauseCnt", resClauseCnt, 1);
    cycles(2);
    resReady = 1'b0;
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
